// File: rtl/fwd_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard_pkg
// Shared definitions for the forwarding/hazard scoreboard:
//   - default datapath and register-address widths
//   - forward-enable encodings and the data-zero fill bit
//   - packed layout of one scoreboard entry: {valid, rdy, addr, data}
//   - forwarding source encoding used by the per-port lookup
// -----------------------------------------------------------------------------
package fwd_scoreboard_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;

    localparam logic FORWARD_ENABLE  = 1'b1;
    localparam logic FORWARD_DISABLE = 1'b0;

    // Replicated to DATA_W wherever a zero data word is driven.
    localparam logic DATA_ZERO = 1'b0;

    // Entry layout, LSB first: data[dw-1:0], addr[dw +: aw], rdy, valid.
    function automatic int ent_w(input int aw, input int dw);
        return dw + aw + 2;
    endfunction

    function automatic int ent_rdy_bit(input int aw, input int dw);
        return dw + aw;
    endfunction

    function automatic int ent_vld_bit(input int aw, input int dw);
        return dw + aw + 1;
    endfunction

    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_ENTRY  = 3'd1,
        SRC_EX     = 3'd2,
        SRC_MEM    = 3'd3,
        SRC_HAZARD = 3'd4
    } fwd_src_e;

endpackage

// File: rtl/fwd_scoreboard_lookup.sv
// -----------------------------------------------------------------------------
// fwd_lookup
// One decode read port: finds the youngest valid in-flight entry whose
// destination matches the source address, then picks the data source
// (entry already ready, EX result bypass, MEM result bypass) or flags a hazard.
// Ports:
//   rd_en_i, rd_addr_i        read request and source register
//   ent_vld_i/ent_rdy_i       per-entry valid/ready flags (entry 0 = youngest)
//   ent_addr_i/ent_data_i     per-entry destination and captured data, flat
//   ex_res_*_i, mem_res_*_i   current-cycle result ports
//   fwd_en_o, fwd_data_o      forwarded data (zero when not forwarding)
//   hazard_o                  match found but its result is not available
// -----------------------------------------------------------------------------
module fwd_lookup
    import fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = 3,
    parameter int MEM_IDX  = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                     rd_en_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic [DEPTH-1:0]         ent_vld_i,
    input  logic [DEPTH-1:0]         ent_rdy_i,
    input  logic [DEPTH*ADDR_W-1:0]  ent_addr_i,
    input  logic [DEPTH*DATA_W-1:0]  ent_data_i,
    input  logic                     ex_res_valid_i,
    input  logic [DATA_W-1:0]        ex_res_data_i,
    input  logic                     mem_res_valid_i,
    input  logic [DATA_W-1:0]        mem_res_data_i,
    output logic                     fwd_en_o,
    output logic [DATA_W-1:0]        fwd_data_o,
    output logic                     hazard_o
);

    logic              zero_blk;
    logic              hit;
    logic              w_rdy;
    logic              w_ex;
    logic              w_mem;
    logic [DATA_W-1:0] w_data;
    fwd_src_e          src;

    assign zero_blk = (ZERO_REG != 0) && (rd_addr_i == '0);

    // Scan oldest to youngest so the youngest match is the last one written.
    always_comb begin
        hit    = 1'b0;
        w_rdy  = 1'b0;
        w_ex   = 1'b0;
        w_mem  = 1'b0;
        w_data = {DATA_W{DATA_ZERO}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rd_en_i && !zero_blk && ent_vld_i[i] &&
                (ent_addr_i[i*ADDR_W +: ADDR_W] == rd_addr_i)) begin
                hit    = 1'b1;
                w_rdy  = ent_rdy_i[i];
                w_data = ent_data_i[i*DATA_W +: DATA_W];
                w_ex   = (i == 0);
                w_mem  = (i == MEM_IDX);
            end
        end
    end

    always_comb begin
        src = SRC_NONE;
        if (hit) begin
            if (w_rdy)                        src = SRC_ENTRY;
            else if (w_ex && ex_res_valid_i)  src = SRC_EX;
            else if (w_mem && mem_res_valid_i) src = SRC_MEM;
            else                              src = SRC_HAZARD;
        end
    end

    always_comb begin
        fwd_en_o   = FORWARD_DISABLE;
        fwd_data_o = {DATA_W{DATA_ZERO}};
        hazard_o   = 1'b0;
        case (src)
            SRC_ENTRY: begin
                fwd_en_o   = FORWARD_ENABLE;
                fwd_data_o = w_data;
            end
            SRC_EX: begin
                fwd_en_o   = FORWARD_ENABLE;
                fwd_data_o = ex_res_data_i;
            end
            SRC_MEM: begin
                fwd_en_o   = FORWARD_ENABLE;
                fwd_data_o = mem_res_data_i;
            end
            SRC_HAZARD: hazard_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_scoreboard
// Forwarding and load-use hazard unit beside decode. A DEPTH-entry shift
// register mirrors the EX..WB pipeline (entry 0 = instruction in EX) and holds
// each in-flight destination plus its result once known. NUM_RD read ports
// get same-cycle forwarded data or raise a stall.
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   issue_*                   instruction leaving decode into EX
//   rd_en, rd_addr            decode read requests, port r at [r*ADDR_W +: ADDR_W]
//   ex_res_*, mem_res_*       results for entry 0 and entry MEM_IDX
//   hold_in, flush_in         global freeze; kill decode/EX instructions
//   fwd_en, fwd_data          per-port forwarded data, port r at [r*DATA_W +: DATA_W]
//   stall_out, stall_cnt      load-use stall and saturating stall-cycle count
// -----------------------------------------------------------------------------
module fwd_scoreboard
    import fwd_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = 3,
    parameter int NUM_RD   = 2,
    parameter int MEM_IDX  = 1,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_wen,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     issue_rdy,
    input  logic [DATA_W-1:0]        issue_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     ex_res_valid,
    input  logic [DATA_W-1:0]        ex_res_data,
    input  logic                     mem_res_valid,
    input  logic [DATA_W-1:0]        mem_res_data,
    input  logic                     hold_in,
    input  logic                     flush_in,
    output logic [NUM_RD-1:0]        fwd_en,
    output logic [NUM_RD*DATA_W-1:0] fwd_data,
    output logic                     stall_out,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int ENT_W = ent_w(ADDR_W, DATA_W);
    localparam int RDY_B = ent_rdy_bit(ADDR_W, DATA_W);
    localparam int VLD_B = ent_vld_bit(ADDR_W, DATA_W);

    logic [ENT_W-1:0]        ent_q [DEPTH];
    logic [ENT_W-1:0]        ent_d [DEPTH];
    logic [ENT_W-1:0]        cap   [DEPTH];
    logic [ENT_W-1:0]        issue_ent;
    logic                    issue_go;
    logic [DEPTH-1:0]        ent_vld;
    logic [DEPTH-1:0]        ent_rdy;
    logic [DEPTH*ADDR_W-1:0] ent_addr;
    logic [DEPTH*DATA_W-1:0] ent_data;
    logic [NUM_RD-1:0]       hazard;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_unpack
        assign ent_vld[i]                    = ent_q[i][VLD_B];
        assign ent_rdy[i]                    = ent_q[i][RDY_B];
        assign ent_addr[i*ADDR_W +: ADDR_W]  = ent_q[i][DATA_W +: ADDR_W];
        assign ent_data[i*DATA_W +: DATA_W]  = ent_q[i][DATA_W-1:0];
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_port
        fwd_lookup #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .DEPTH    (DEPTH),
            .MEM_IDX  (MEM_IDX),
            .ZERO_REG (ZERO_REG)
        ) u_lookup (
            .rd_en_i         (rd_en[r]),
            .rd_addr_i       (rd_addr[r*ADDR_W +: ADDR_W]),
            .ent_vld_i       (ent_vld),
            .ent_rdy_i       (ent_rdy),
            .ent_addr_i      (ent_addr),
            .ent_data_i      (ent_data),
            .ex_res_valid_i  (ex_res_valid),
            .ex_res_data_i   (ex_res_data),
            .mem_res_valid_i (mem_res_valid),
            .mem_res_data_i  (mem_res_data),
            .fwd_en_o        (fwd_en[r]),
            .fwd_data_o      (fwd_data[r*DATA_W +: DATA_W]),
            .hazard_o        (hazard[r])
        );
    end

    // A frozen or flushed decode is not waiting on anything, so no stall.
    assign stall_out = (|hazard) & ~hold_in & ~flush_in;

    assign issue_go  = issue_valid & issue_wen & ~stall_out & ~flush_in;
    assign issue_ent = issue_go ? {1'b1, issue_rdy, issue_addr, issue_data} : '0;

    // Results land on the entry's current content; the shift below then
    // carries the captured value to wherever that entry goes next.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cap[i] = ent_q[i];
            if (i == 0 && ex_res_valid && ent_q[i][VLD_B]) begin
                cap[i][RDY_B]      = 1'b1;
                cap[i][DATA_W-1:0] = ex_res_data;
            end
            if (i == MEM_IDX && mem_res_valid && ent_q[i][VLD_B]) begin
                cap[i][RDY_B]      = 1'b1;
                cap[i][DATA_W-1:0] = mem_res_data;
            end
        end
    end

    always_comb begin
        ent_d[0] = hold_in ? cap[0] : issue_ent;
        for (int i = 1; i < DEPTH; i++) begin
            ent_d[i] = hold_in ? cap[i] : cap[i-1];
        end
    end

    assign cnt_d = (stall_out && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_wen;
    logic [3:0]  issue_addr;
    logic        issue_rdy;
    logic [15:0] issue_data;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic        ex_res_valid;
    logic [15:0] ex_res_data;
    logic        mem_res_valid;
    logic [15:0] mem_res_data;
    logic        hold_in;
    logic        flush_in;

    logic [1:0]  fwd_en;
    logic [31:0] fwd_data;
    logic        stall_out;
    logic [15:0] stall_cnt;

    logic [1:0]  fwd_en_z;
    logic [31:0] fwd_data_z;
    logic        stall_z;
    logic [1:0]  cnt_z;

    int checks;
    int failures;

    fwd_scoreboard #(
        .DATA_W(16), .ADDR_W(4), .DEPTH(3), .NUM_RD(2),
        .MEM_IDX(1), .ZERO_REG(0), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_addr(issue_addr),
        .issue_rdy(issue_rdy), .issue_data(issue_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .ex_res_valid(ex_res_valid), .ex_res_data(ex_res_data),
        .mem_res_valid(mem_res_valid), .mem_res_data(mem_res_data),
        .hold_in(hold_in), .flush_in(flush_in),
        .fwd_en(fwd_en), .fwd_data(fwd_data),
        .stall_out(stall_out), .stall_cnt(stall_cnt)
    );

    // Second instance: zero register excluded, 2-bit counter to reach saturation.
    fwd_scoreboard #(
        .DATA_W(16), .ADDR_W(4), .DEPTH(3), .NUM_RD(2),
        .MEM_IDX(1), .ZERO_REG(1), .CNT_W(2)
    ) u_dut_z (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_addr(issue_addr),
        .issue_rdy(issue_rdy), .issue_data(issue_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .ex_res_valid(ex_res_valid), .ex_res_data(ex_res_data),
        .mem_res_valid(mem_res_valid), .mem_res_data(mem_res_data),
        .hold_in(hold_in), .flush_in(flush_in),
        .fwd_en(fwd_en_z), .fwd_data(fwd_data_z),
        .stall_out(stall_z), .stall_cnt(cnt_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        iw;
        logic [3:0]  ia;
        logic        ir;
        logic [15:0] id;
        logic [1:0]  rden;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic        exv;
        logic [15:0] exd;
        logic        memv;
        logic [15:0] memd;
        logic        hold;
        logic        flush;
        logic [1:0]  een;
        logic [15:0] ed0;
        logic [15:0] ed1;
        logic        est;
        logic [15:0] ecnt;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input int iv, input int iw, input int ia, input int ir,
                                input int id, input int rden, input int ra0, input int ra1,
                                input int exv, input int exd, input int memv, input int memd,
                                input int hold, input int flush, input int een,
                                input int ed0, input int ed1, input int est, input int ecnt);
        vec_t v;
        v.iv = 1'(iv);     v.iw = 1'(iw);     v.ia = 4'(ia);     v.ir = 1'(ir);
        v.id = 16'(id);    v.rden = 2'(rden); v.ra0 = 4'(ra0);   v.ra1 = 4'(ra1);
        v.exv = 1'(exv);   v.exd = 16'(exd);  v.memv = 1'(memv); v.memd = 16'(memd);
        v.hold = 1'(hold); v.flush = 1'(flush);
        v.een = 2'(een);   v.ed0 = 16'(ed0);  v.ed1 = 16'(ed1);
        v.est = 1'(est);   v.ecnt = 16'(ecnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        issue_valid = 1'b0; issue_wen = 1'b0; issue_addr = '0;
        issue_rdy = 1'b0; issue_data = '0;
        rd_en = '0; rd_addr = '0;
        ex_res_valid = 1'b0; ex_res_data = '0;
        mem_res_valid = 1'b0; mem_res_data = '0;
        hold_in = 1'b0; flush_in = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        issue_valid = v.iv; issue_wen = v.iw; issue_addr = v.ia;
        issue_rdy = v.ir; issue_data = v.id;
        rd_en = v.rden; rd_addr = {v.ra1, v.ra0};
        ex_res_valid = v.exv; ex_res_data = v.exd;
        mem_res_valid = v.memv; mem_res_data = v.memd;
        hold_in = v.hold; flush_in = v.flush;
    endtask

    initial begin
        checks = 0;
        failures = 0;

        // iv iw ia ir id | rden ra0 ra1 | exv exd memv memd | hold flush | een ed0 ed1 est cnt
        vecs[0]  = mk(0,0,0,0,0,        3,3,3,   0,0,0,0,          0,0, 0,0,0,0,0);
        vecs[1]  = mk(1,1,3,0,0,        0,0,0,   0,0,0,0,          0,0, 0,0,0,0,0);
        vecs[2]  = mk(0,0,0,0,0,        1,3,0,   1,'h1234,0,0,     0,0, 1,'h1234,0,0,0);
        vecs[3]  = mk(0,0,0,0,0,        3,4,3,   0,0,0,0,          0,0, 2,0,'h1234,0,0);
        vecs[4]  = mk(1,1,5,0,0,        1,3,0,   0,0,0,0,          0,0, 1,'h1234,0,0,0);
        vecs[5]  = mk(1,1,6,0,0,        1,5,0,   0,0,0,0,          0,0, 0,0,0,1,0);
        vecs[6]  = mk(1,1,6,0,0,        1,5,0,   0,0,1,'hBEEF,     0,0, 1,'hBEEF,0,0,1);
        vecs[7]  = mk(0,0,0,0,0,        3,5,6,   1,'h0606,0,0,     0,0, 3,'hBEEF,'h0606,0,1);
        vecs[8]  = mk(1,1,2,1,'h0001,   2,0,6,   0,0,0,0,          0,0, 2,0,'h0606,0,1);
        vecs[9]  = mk(1,1,2,1,'h0002,   3,2,6,   0,0,0,0,          0,0, 3,'h0001,'h0606,0,1);
        vecs[10] = mk(0,0,0,0,0,        3,2,2,   0,0,0,0,          0,0, 3,'h0002,'h0002,0,1);
        vecs[11] = mk(0,0,0,0,0,        3,2,2,   0,0,0,0,          0,0, 3,'h0002,'h0002,0,1);
        vecs[12] = mk(1,1,7,1,'h00AA,   1,2,0,   0,0,0,0,          0,0, 1,'h0002,0,0,1);
        vecs[13] = mk(0,0,0,0,0,        1,7,0,   0,0,0,0,          0,0, 1,'h00AA,0,0,1);
        vecs[14] = mk(0,0,0,0,0,        1,7,0,   0,0,0,0,          0,0, 1,'h00AA,0,0,1);
        vecs[15] = mk(0,0,0,0,0,        1,7,0,   0,0,0,0,          0,0, 1,'h00AA,0,0,1);
        vecs[16] = mk(0,0,0,0,0,        1,7,0,   0,0,0,0,          0,0, 0,0,0,0,1);
        vecs[17] = mk(1,1,9,0,0,        0,0,0,   0,0,0,0,          0,0, 0,0,0,0,1);
        vecs[18] = mk(1,1,10,0,0,       1,9,0,   0,0,0,0,          1,0, 0,0,0,0,1);
        vecs[19] = mk(1,1,10,0,0,       1,9,0,   0,0,0,0,          1,0, 0,0,0,0,1);
        vecs[20] = mk(0,0,0,0,0,        1,9,0,   1,'h0909,0,0,     1,0, 1,'h0909,0,0,1);
        vecs[21] = mk(1,1,10,0,0,       1,9,0,   0,0,0,0,          0,1, 1,'h0909,0,0,1);
        vecs[22] = mk(0,0,0,0,0,        3,10,9,  0,0,0,0,          0,0, 2,0,'h0909,0,1);
        vecs[23] = mk(1,1,11,0,0,       0,0,0,   0,0,0,0,          0,0, 0,0,0,0,1);
        vecs[24] = mk(0,0,0,0,0,        2,0,11,  0,0,0,0,          0,0, 0,0,0,1,1);
        vecs[25] = mk(0,0,0,0,0,        2,0,11,  0,0,0,0,          0,0, 0,0,0,1,2);
        vecs[26] = mk(0,0,0,0,0,        2,0,11,  0,0,1,'h7777,     0,0, 0,0,0,1,3);

        clear_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_fwd_en", 32'(fwd_en), 32'h0);
        chk("reset_stall", 32'(stall_out), 32'h0);
        chk("reset_cnt", 32'(stall_cnt), 32'h0);
        rst = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk);
            apply(vecs[k]);
            #2;
            chk($sformatf("v%0d_fwd_en", k), 32'(fwd_en), 32'(vecs[k].een));
            chk($sformatf("v%0d_fwd_data", k), fwd_data, {vecs[k].ed1, vecs[k].ed0});
            chk($sformatf("v%0d_stall", k), 32'(stall_out), 32'(vecs[k].est));
            chk($sformatf("v%0d_cnt", k), 32'(stall_cnt), 32'(vecs[k].ecnt));
            chk($sformatf("v%0d_cnt_sat", k), 32'(cnt_z),
                (vecs[k].ecnt > 16'd3) ? 32'd3 : 32'(vecs[k].ecnt));
        end

        // Reset asserted while a load-use stall is active.
        @(negedge clk);
        clear_inputs();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_addr = 4'd12;
        @(negedge clk);
        clear_inputs();
        rd_en = 2'b01; rd_addr = {4'd0, 4'd12};
        #2;
        chk("prerst_stall", 32'(stall_out), 32'h1);
        chk("prerst_cnt", 32'(stall_cnt), 32'd4);
        chk("prerst_cnt_sat", 32'(cnt_z), 32'd3);
        #1 rst = 1'b0;
        #1;
        chk("asyncrst_stall", 32'(stall_out), 32'h0);
        chk("asyncrst_fwd_en", 32'(fwd_en), 32'h0);
        chk("asyncrst_fwd_data", fwd_data, 32'h0);
        chk("asyncrst_cnt", 32'(stall_cnt), 32'h0);
        chk("asyncrst_cnt_sat", 32'(cnt_z), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("postrst_fwd_en", 32'(fwd_en), 32'h0);
        chk("postrst_stall", 32'(stall_out), 32'h0);

        // Register 0: tracked normally, excluded when ZERO_REG=1.
        @(negedge clk);
        clear_inputs();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_addr = 4'd0;
        issue_rdy = 1'b1; issue_data = 16'h00F0;
        @(negedge clk);
        clear_inputs();
        rd_en = 2'b01; rd_addr = 8'h00;
        #2;
        chk("r0_fwd_en", 32'(fwd_en), 32'h1);
        chk("r0_fwd_data", fwd_data, 32'h0000_00F0);
        chk("zreg_fwd_en", 32'(fwd_en_z), 32'h0);
        chk("zreg_fwd_data", fwd_data_z, 32'h0);
        chk("zreg_stall", 32'(stall_z), 32'h0);

        @(negedge clk);
        clear_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
